// File: rtl/instruction_loader.sv
// Assembles little-endian bytes from a serial receiver into 32-bit words and
// writes them into instruction memory until a halt word is seen or memory is full.
module instruction_loader #(
   parameter int unsigned     SIZE            = 32,
   parameter int unsigned     MAX_INSTRUCTION = 64,
   parameter int unsigned     ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
   parameter logic [SIZE-1:0] HALT_WORD       = 32'hFFFFFFFF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_inst_write_enable,
   output logic [ADDR_WIDTH-1:0] o_write_addr,
   output logic [SIZE-1:0]       o_write_data,
   output logic                  o_loading,
   output logic                  o_done,
   output logic [ADDR_WIDTH:0]   o_word_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RECV  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MAX_INSTRUCTION - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);

   logic [1:0]            state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [SIZE-1:0]       data_q, data_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  we_q, loading_q, done_q;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      count_d    = count_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d    = RECV;
               byte_cnt_d = 2'd0;
               addr_d     = '0;
               count_d    = '0;
            end
         end
         RECV: begin
            if (i_rx_valid) begin
               data_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            count_d    = count_q + COUNT_ONE;
            byte_cnt_d = 2'd0;
            if (data_q == HALT_WORD || addr_q == LAST_ADDR) begin
               state_d = DONE;
            end else begin
               state_d = RECV;
               addr_d  = addr_q + ADDR_ONE;
               // A byte arriving during the write slot starts the next word.
               if (i_rx_valid) begin
                  data_d[7:0] = i_rx_data;
                  byte_cnt_d  = 2'd1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         byte_cnt_q <= 2'd0;
         addr_q     <= '0;
         data_q     <= '0;
         count_q    <= '0;
         we_q       <= 1'b0;
         loading_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         count_q    <= count_d;
         we_q       <= (state_d == WRITE);
         loading_q  <= (state_d == RECV) || (state_d == WRITE);
         done_q     <= (state_d == DONE);
      end
   end

   assign o_inst_write_enable = we_q;
   assign o_write_addr        = addr_q;
   assign o_write_data        = data_q;
   assign o_loading           = loading_q;
   assign o_done              = done_q;
   assign o_word_count        = count_q;

endmodule
